updown_bcd_counter: RTL and testbench

//  Parametrised up/down counter with wrap, saturate, bounce and hold modes,

---
 rtl/updown_bcd_counter_if.sv | 26 ++
 rtl/updown_bcd_counter.sv | 176 +++++++++++++++++
 tb/tb_updown_bcd_counter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_bcd_counter_if.sv
// Control and display bus between the tick source, the up/down BCD counter and the display driver.
interface updown_bcd_counter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  tick;
  logic                  dir;
  logic [1:0]            mode;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      count;
  logic                  at_max;
  logic                  at_min;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;

  modport master (
    output tick, dir, mode, load, load_val,
    input  count, at_max, at_min, bcd, bcd_valid
  );

  modport slave (
    input  tick, dir, mode, load, load_val,
    output count, at_max, at_min, bcd, bcd_valid
  );
endinterface

// File: rtl/updown_bcd_counter.sv
// Up/down counter (wrap/saturate/bounce/hold) with synchronous load and a
// sequential double-dabble converter producing leading-zero-blanked BCD digits.
module updown_bcd_counter #(
  parameter int         WIDTH      = 8,
  parameter int         MIN_VAL    = 0,
  parameter int         MAX_VAL    = 199,
  parameter int         DIGITS     = 3,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  updown_bcd_counter_if.slave bus
);

  localparam int               SCR_W  = 4 * DIGITS;
  localparam int               CNT_W  = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_P1 = WIDTH'(MIN_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX_VAL - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_SAT    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic             dir_q;
  logic             dir_nxt;
  logic             count_change;
  logic             pending;
  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] bin_p0;
  logic [SCR_W-1:0] scr_p0;
  logic [SCR_W-1:0] bcd_p1;
  logic             vld_p1;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    if (int'(v) < MIN_VAL) return MIN_V;
    if (int'(v) > MAX_VAL) return MAX_V;
    return v;
  endfunction

  function automatic logic [SCR_W-1:0] dabble_adjust(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [SCR_W-1:0] blank_zeros(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    logic             lead;
    r    = s;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (s[4*i +: 4] == 4'd0)) r[4*i +: 4] = BLANK_CODE;
      else                               lead        = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    count_nxt = count_q;
    dir_nxt   = dir_q;
    if (bus.load) begin
      count_nxt = clamp(bus.load_val);
    end else if (bus.tick) begin
      case (bus.mode)
        MODE_WRAP: begin
          if (bus.dir) count_nxt = (count_q == MAX_V) ? MIN_V : count_q + ONE;
          else         count_nxt = (count_q == MIN_V) ? MAX_V : count_q - ONE;
        end
        MODE_SAT: begin
          if (bus.dir) count_nxt = (count_q == MAX_V) ? MAX_V : count_q + ONE;
          else         count_nxt = (count_q == MIN_V) ? MIN_V : count_q - ONE;
        end
        MODE_BOUNCE: begin
          // Reflect off the limit in one step so the limit value is shown once
          if (dir_q) begin
            if (count_q == MAX_V) begin
              count_nxt = MAX_M1;
              dir_nxt   = 1'b0;
            end else begin
              count_nxt = count_q + ONE;
            end
          end else begin
            if (count_q == MIN_V) begin
              count_nxt = MIN_P1;
              dir_nxt   = 1'b1;
            end else begin
              count_nxt = count_q - ONE;
            end
          end
        end
        MODE_HOLD: count_nxt = count_q;
        default:   count_nxt = count_q;
      endcase
    end
  end

  assign count_change = (count_nxt != count_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= MIN_V;
      dir_q   <= 1'b1;
    end else begin
      count_q <= count_nxt;
      dir_q   <= dir_nxt;
    end
  end

  // Converter control: a change always re-arms pending, so a count moving
  // during SHIFT/DONE is picked up by the next conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pending <= 1'b1;
      bit_cnt <= '0;
      bcd_p1  <= {DIGITS{BLANK_CODE}};
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (pending) state <= S_SHIFT;
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(WIDTH - 1)) state <= S_DONE;
        end
        S_DONE: begin
          bcd_p1 <= blank_zeros(scr_p0);
          vld_p1 <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (count_change)          pending <= 1'b1;
      else if (state == S_IDLE)  pending <= 1'b0;
    end
  end

  // Stage p0: binary capture and double-dabble scratch
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (pending) begin
          bin_p0 <= count_q;
          scr_p0 <= '0;
        end
      end
      S_SHIFT: {scr_p0, bin_p0} <= {dabble_adjust(scr_p0), bin_p0} << 1;
      default: ;
    endcase
  end

  // Stage p1: registered display digits and their valid strobe
  assign bus.count     = count_q;
  assign bus.at_max    = (count_q == MAX_V);
  assign bus.at_min    = (count_q == MIN_V);
  assign bus.bcd       = bcd_p1;
  assign bus.bcd_valid = vld_p1;

endmodule

// File: tb/tb_updown_bcd_counter.sv
// Randomised and directed bench for updown_bcd_counter with a queue-based scoreboard.
module tb_updown_bcd_counter;
  localparam int WIDTH   = 8;
  localparam int MIN_VAL = 0;
  localparam int MAX_VAL = 199;
  localparam int DIGITS  = 3;
  localparam int BW      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  updown_bcd_counter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus();

  updown_bcd_counter #(
    .WIDTH(WIDTH), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL),
    .DIGITS(DIGITS), .BLANK_CODE(4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { int count; bit rst_edge; } cyc_t;
  typedef struct { int val; int edge_no; } conv_t;

  cyc_t  cq[$];
  conv_t bq[$];
  int errors = 0;
  int checks = 0;
  int nvalid = 0;
  int edge_no = 0;

  // Reference model state
  int m_count = MIN_VAL;
  bit m_up    = 1'b1;
  bit m_pend  = 1'b1;
  bit m_busy  = 1'b0;
  int m_end   = 0;

  function automatic logic [BW-1:0] fmt(input int v);
    logic [BW-1:0] r;
    bit lead;
    int d;
    lead = 1'b1;
    r = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = (v / (10 ** i)) % 10;
      if (lead && d == 0 && i > 0) r[4*i +: 4] = 4'hF;
      else begin
        r[4*i +: 4] = 4'(d);
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic int lim(input int v);
    if (v < MIN_VAL) return MIN_VAL;
    if (v > MAX_VAL) return MAX_VAL;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one clock: apply the specification rules to the current inputs,
  // push expectations, then wait for the following falling edge.
  task automatic step();
    int old, nxt, rng, p;
    edge_no++;
    if (rst) begin
      m_count = MIN_VAL; m_up = 1'b1; m_pend = 1'b1; m_busy = 1'b0;
      bq.delete();
    end else begin
      old = m_count;
      nxt = old;
      rng = MAX_VAL - MIN_VAL + 1;
      if (bus.load) nxt = lim(int'(bus.load_val));
      else if (bus.tick) begin
        case (bus.mode)
          2'b00: nxt = MIN_VAL + ((old - MIN_VAL + (bus.dir ? 1 : rng - 1)) % rng);
          2'b01: nxt = lim(old + (bus.dir ? 1 : -1));
          2'b10: begin
            p = old + (m_up ? 1 : -1);
            if (p > MAX_VAL) begin p = 2 * MAX_VAL - p; m_up = 1'b0; end
            if (p < MIN_VAL) begin p = 2 * MIN_VAL - p; m_up = 1'b1; end
            nxt = p;
          end
          default: nxt = old;
        endcase
      end
      if (m_busy && edge_no == m_end) m_busy = 1'b0;
      else if (!m_busy && m_pend) begin
        bq.push_back('{old, edge_no + WIDTH + 1});
        m_busy = 1'b1;
        m_end  = edge_no + WIDTH + 1;
        m_pend = 1'b0;
      end
      if (nxt != old) m_pend = 1'b1;
      m_count = nxt;
    end
    cq.push_back('{m_count, rst});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.tick = 1'b0; bus.load = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_tick(input bit d, input logic [1:0] m);
    bus.tick = 1'b1; bus.load = 1'b0; bus.dir = d; bus.mode = m;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic do_load(input int v);
    bus.load = 1'b1; bus.tick = 1'b0; bus.load_val = WIDTH'(v);
    step();
    bus.load = 1'b0;
  endtask

  // Monitor: one count expectation per edge, one digit expectation per bcd_valid
  initial begin
    int mcyc;
    cyc_t c;
    conv_t b;
    logic [BW-1:0] prev_bcd;
    mcyc = 0;
    prev_bcd = '1;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      if (cq.size() == 0) begin
        checks++; errors++;
        $display("FAIL no_expectation: edge %0d has no model entry", mcyc);
      end else begin
        c = cq.pop_front();
        checks++;
        if (int'(bus.count) != c.count || bus.at_max !== (c.count == MAX_VAL) ||
            bus.at_min !== (c.count == MIN_VAL)) begin
          errors++;
          $display("FAIL count@%0d: got %0d max=%0b min=%0b expected %0d", mcyc,
                   bus.count, bus.at_max, bus.at_min, c.count);
        end
        if (c.rst_edge) begin
          checks++;
          if (bus.bcd !== '1 || bus.bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_bcd@%0d: got bcd=%h valid=%b expected fff/0", mcyc,
                     bus.bcd, bus.bcd_valid);
          end
        end else if (bus.bcd_valid === 1'b1) begin
          nvalid++;
          checks++;
          if (bq.size() == 0) begin
            errors++;
            $display("FAIL bcd_unexpected@%0d: got bcd=%h with no conversion due", mcyc, bus.bcd);
          end else begin
            b = bq.pop_front();
            if (bus.bcd !== fmt(b.val) || b.edge_no != mcyc) begin
              errors++;
              $display("FAIL bcd@%0d: got %h expected %h due at edge %0d", mcyc,
                       bus.bcd, fmt(b.val), b.edge_no);
            end
          end
        end else begin
          checks++;
          if (bus.bcd !== prev_bcd || bus.bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL bcd_stable@%0d: got %h valid=%b expected %h", mcyc,
                     bus.bcd, bus.bcd_valid, prev_bcd);
          end
          if (bq.size() != 0 && bq[0].edge_no <= mcyc) begin
            checks++; errors++;
            $display("FAIL bcd_late@%0d: no pulse, expected %h at edge %0d", mcyc,
                     fmt(bq[0].val), bq[0].edge_no);
            void'(bq.pop_front());
          end
        end
      end
      prev_bcd = bus.bcd;
    end
  end

  initial begin
    int v0, r;
    rst = 1'b1;
    bus.tick = 1'b0; bus.dir = 1'b1; bus.mode = 2'b00;
    bus.load = 1'b0; bus.load_val = '0;
    step(); step();

    // Reset release and first conversion
    rst = 1'b0;
    idle(10);
    chk("t1_count", int'(bus.count), 0);
    chk("t1_bcd", int'(bus.bcd), 'hFF0);
    chk("t1_pulses", nvalid, 1);

    // Wrap up through MAX
    bus.mode = 2'b00; bus.dir = 1'b1;
    do_load(198);
    do_tick(1'b1, 2'b00); chk("t2_199", int'(bus.count), 199); chk("t2_atmax", int'(bus.at_max), 1);
    do_tick(1'b1, 2'b00); chk("t2_0", int'(bus.count), 0);     chk("t2_atmax0", int'(bus.at_max), 0);
    do_tick(1'b1, 2'b00); chk("t2_1", int'(bus.count), 1);
    idle(22);
    chk("t2_bcd", int'(bus.bcd), 'hFF1);

    // Saturate at MIN
    do_load(1);
    repeat (3) do_tick(1'b0, 2'b01);
    chk("t3_0", int'(bus.count), 0);
    chk("t3_atmin", int'(bus.at_min), 1);
    do_tick(1'b1, 2'b01);
    chk("t3_up", int'(bus.count), 1);

    // Bounce off both limits
    bus.mode = 2'b10;
    do_load(198);
    do_tick(1'b1, 2'b10); chk("t4_199", int'(bus.count), 199);
    do_tick(1'b1, 2'b10); chk("t4_198", int'(bus.count), 198);
    do_tick(1'b1, 2'b10);
    do_tick(1'b1, 2'b10); chk("t4_196", int'(bus.count), 196);
    do_load(1);
    do_tick(1'b1, 2'b10); chk("t4_0", int'(bus.count), 0);
    do_tick(1'b1, 2'b10); chk("t4_1", int'(bus.count), 1);

    // Load clamp and load-over-tick priority
    bus.mode = 2'b00;
    do_load(250);
    chk("t5_clamp", int'(bus.count), 199);
    bus.tick = 1'b1; bus.dir = 1'b1; bus.load = 1'b1; bus.load_val = 8'd7;
    step();
    bus.tick = 1'b0; bus.load = 1'b0;
    chk("t5_prio", int'(bus.count), 7);

    // Burst of ticks during a conversion
    do_load(10);
    idle(25);
    v0 = nvalid;
    repeat (5) do_tick(1'b1, 2'b00);
    chk("t6_count", int'(bus.count), 15);
    idle(18);
    chk("t6_pulses", nvalid - v0, 2);
    chk("t6_bcd", int'(bus.bcd), 'hF15);

    // Reset in the middle of SHIFT
    do_tick(1'b1, 2'b00);
    idle(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_bcd_blank", int'(bus.bcd), 'hFFF);
    chk("t7_valid0", int'(bus.bcd_valid), 0);
    idle(10);
    chk("t7_bcd", int'(bus.bcd), 'hFF0);
    chk("t7_valid", int'(bus.bcd_valid), 1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      rst = (r == 0);
      bus.mode = 2'($urandom_range(0, 3));
      bus.dir = 1'($urandom_range(0, 1));
      bus.load = (r >= 1 && r < 12);
      bus.load_val = WIDTH'($urandom_range(0, 255));
      bus.tick = (r >= 8 && r < 60);
      step();
    end
    rst = 1'b0;
    idle(25);
    chk("drain", bq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
